// File: rtl/lsu_bus_if.sv
// Data-memory bus between the load/store bridge and memory.
// Registered req/ack handshake with byte enables.
interface lsu_bus_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/lsu_bus_bridge.sv
// Load/store bridge: datapath memory request -> req/ack bus.
// Stalls the core until done, returns lane-aligned read word.
module lsu_bus_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MisalignErr,
    output logic        BusErr,
    lsu_bus_if.master   bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        req_q, we_q, err_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  be_q;
    logic [1:0]  off_q;
    logic [7:0]  cnt_q;

    logic [1:0]  off;
    logic        is_byte, is_half, mis, mem, acc;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic        unused_f3;

    assign unused_f3 = Funct3[2];

    // Size decode, misalignment, lane enables and replicated store data
    always_comb begin
        off     = Addr[1:0];
        is_byte = (Funct3[1:0] == 2'b00);
        is_half = (Funct3[1:0] == 2'b01);
        mis     = 1'b0;
        be_d    = 4'b1111;
        wdata_d = WriteData;
        if (is_byte) begin
            be_d    = 4'b0001 << off;
            wdata_d = {4{WriteData[7:0]}};
        end else if (is_half) begin
            mis     = Addr[0];
            be_d    = 4'b0011 << off;
            wdata_d = {2{WriteData[15:0]}};
        end else begin
            mis     = (off != 2'b00);
        end
        mem = MemRead | MemWrite;
        acc = mem & ~mis & reset;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state, stall and misalign flag
    always_comb begin
        state_d     = state_q;
        Stall       = 1'b0;
        MisalignErr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    Stall   = 1'b1;
                    state_d = BUSY;
                end else if (mem && mis) begin
                    MisalignErr = 1'b1;
                end
            end
            BUSY: begin
                Stall = 1'b1;
                if (bus.bus_ack || cnt_q == LAST)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture, bus request, timeout count and read-data latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (acc) begin
                        req_q   <= 1'b1;
                        we_q    <= MemWrite;
                        addr_q  <= {Addr[31:2], 2'b00};
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        off_q   <= off;
                        cnt_q   <= '0;
                    end
                end
                BUSY: begin
                    if (bus.bus_ack) begin
                        req_q <= 1'b0;
                        if (!we_q)
                            rdata_q <= bus.bus_rdata >> {off_q, 3'b000};
                    end else if (cnt_q == LAST) begin
                        req_q   <= 1'b0;
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: req_q <= 1'b0;
            endcase
        end
    end

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;
    assign ReadData      = rdata_q;
    assign BusErr        = err_q;
endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed bench for lsu_bus_bridge with a short bus timeout.
// Hand-computed expectations for stores, loads, misalign, timeout, reset.
module tb_lsu_bus_bridge;
    logic        clk;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Addr, WriteData, ReadData;
    logic        Stall, MisalignErr, BusErr;
    int          total, bad;

    lsu_bus_if bus ();

    lsu_bus_bridge #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .Funct3      (Funct3),
        .Addr        (Addr),
        .WriteData   (WriteData),
        .ReadData    (ReadData),
        .Stall       (Stall),
        .MisalignErr (MisalignErr),
        .BusErr      (BusErr),
        .bus         (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Funct3    = 3'b000;
        Addr      = '0;
        WriteData = '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle_in();
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = '0;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req",   32'(bus.bus_req), 0);
        check("rst_stall", 32'(Stall), 0);
        check("rst_err",   32'(BusErr), 0);
        check("rst_rd",    ReadData, 0);
        check("rst_be",    32'(bus.bus_be), 0);
        check("rst_addr",  bus.bus_addr, 0);
        reset = 1'b1;
        @(negedge clk);
        check("nomem_stall", 32'(Stall), 0);

        // SW 0x100, ack in second BUSY cycle
        MemWrite = 1'b1; Funct3 = 3'b010;
        Addr = 32'h100; WriteData = 32'h12345678;
        #1 check("sw_stall0", 32'(Stall), 1);
        @(negedge clk);
        check("sw_req",   32'(bus.bus_req), 1);
        check("sw_we",    32'(bus.bus_we), 1);
        check("sw_be",    32'(bus.bus_be), 32'hF);
        check("sw_wdata", bus.bus_wdata, 32'h12345678);
        check("sw_addr",  bus.bus_addr, 32'h100);
        check("sw_stall1", 32'(Stall), 1);
        @(negedge clk);
        check("sw_stall2", 32'(Stall), 1);
        check("sw_req2",   32'(bus.bus_req), 1);
        bus.bus_ack = 1'b1;
        @(negedge clk);
        bus.bus_ack = 1'b0;
        check("sw_done_stall", 32'(Stall), 0);
        check("sw_done_req",   32'(bus.bus_req), 0);
        idle_in();
        @(negedge clk);
        check("sw_idle_req", 32'(bus.bus_req), 0);

        // LB 0x1003, ack in first BUSY cycle
        MemRead = 1'b1; Funct3 = 3'b000; Addr = 32'h1003;
        @(negedge clk);
        check("lb_be",   32'(bus.bus_be), 32'h8);
        check("lb_we",   32'(bus.bus_we), 0);
        check("lb_addr", bus.bus_addr, 32'h1000);
        bus.bus_ack = 1'b1; bus.bus_rdata = 32'hAABBCCDD;
        @(negedge clk);
        bus.bus_ack = 1'b0;
        check("lb_rd",    ReadData, 32'h000000AA);
        check("lb_stall", 32'(Stall), 0);
        idle_in();
        @(negedge clk);

        // SH 0x1001 misaligned
        MemWrite = 1'b1; Funct3 = 3'b001; Addr = 32'h1001;
        #1 check("sh_mis",   32'(MisalignErr), 1);
        check("sh_stall", 32'(Stall), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sh_noreq", 32'(bus.bus_req), 0);
        end
        idle_in();
        #1 check("sh_mis_clr", 32'(MisalignErr), 0);
        @(negedge clk);

        // stray ack in IDLE is ignored
        bus.bus_ack = 1'b1;
        @(negedge clk);
        bus.bus_ack = 1'b0;
        check("stray_req", 32'(bus.bus_req), 0);
        check("stray_rd",  ReadData, 32'h000000AA);

        // SB 0x2002; ReadData keeps last load value
        MemWrite = 1'b1; Funct3 = 3'b000;
        Addr = 32'h2002; WriteData = 32'h000000EF;
        @(negedge clk);
        check("sb_be",    32'(bus.bus_be), 32'h4);
        check("sb_wdata", bus.bus_wdata, 32'hEFEFEFEF);
        bus.bus_ack = 1'b1; bus.bus_rdata = 32'h55555555;
        @(negedge clk);
        bus.bus_ack = 1'b0;
        check("sb_rd_keep", ReadData, 32'h000000AA);
        idle_in();
        @(negedge clk);

        // LH 0x2002 -> upper half
        MemRead = 1'b1; Funct3 = 3'b001; Addr = 32'h2002;
        @(negedge clk);
        check("lh_be", 32'(bus.bus_be), 32'hC);
        bus.bus_ack = 1'b1; bus.bus_rdata = 32'h11223344;
        @(negedge clk);
        bus.bus_ack = 1'b0;
        check("lh_rd", ReadData, 32'h00001122);
        idle_in();
        @(negedge clk);

        // LW with no ack -> timeout after 4 BUSY cycles
        MemRead = 1'b1; Funct3 = 3'b010; Addr = 32'h3000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("to_req",   32'(bus.bus_req), 1);
            check("to_stall", 32'(Stall), 1);
            check("to_noerr", 32'(BusErr), 0);
        end
        @(negedge clk);
        check("to_err",     32'(BusErr), 1);
        check("to_rd",      ReadData, 0);
        check("to_done_rq", 32'(bus.bus_req), 0);
        check("to_done_st", 32'(Stall), 0);
        idle_in();
        @(negedge clk);
        check("to_err_clr", 32'(BusErr), 0);

        // reset mid-BUSY, then same LW issues normally
        MemRead = 1'b1; Funct3 = 3'b010; Addr = 32'h4000;
        @(negedge clk);
        check("rb_req", 32'(bus.bus_req), 1);
        #2 reset = 1'b0;
        #1 check("rb_req_drop",   32'(bus.bus_req), 0);
        check("rb_stall_drop", 32'(Stall), 0);
        @(negedge clk);
        reset = 1'b1;
        #1 check("rb_reissue_st", 32'(Stall), 1);
        @(negedge clk);
        check("rb_req2",  32'(bus.bus_req), 1);
        check("rb_addr2", bus.bus_addr, 32'h4000);
        bus.bus_ack = 1'b1; bus.bus_rdata = 32'hCAFEBABE;
        @(negedge clk);
        bus.bus_ack = 1'b0;
        check("rb_rd", ReadData, 32'hCAFEBABE);
        idle_in();
        @(negedge clk);
        check("rb_idle", 32'(Stall), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
